mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage data-memory controller, directly downstream of the EX/MEM pipeline register. Takes
//  the registered aligned address, byte offset, byte enables, store data and control, runs one
//  dmem read/write handshake per instruction, and stalls the pipeline until dmem_resp. Returns
//  load data shifted and sign/zero-extended for MEM/WB. Also flags misaligned accesses and timeouts.
// PARAMETERS
//  TIMEOUT_CYCLES  256  BUSY cycles without dmem_resp before the access is abandoned
// PORTS
//  clk             in   1   clock
//  rst             in   1   reset (one clock; reset is asynchronous and active-low)
//  mem_read        in   1   EX/MEM ctrl: instruction is a load
//  mem_write       in   1   EX/MEM ctrl: instruction is a store
//  funct3          in   3   EX/MEM ctrl funct3 (load_funct3_t / store_funct3_t)
//  addr_aligned    in   32  EX/MEM word-aligned address
//  bit_shift       in   2   EX/MEM byte offset addr[1:0]
//  mem_byte_enable in   4   EX/MEM byte mask (already shifted by offset)
//  write_data      in   32  EX/MEM raw rs2 value (unshifted)
//  dmem_read       out  1   read request to data memory
//  dmem_write      out  1   write request to data memory
//  dmem_address    out  32  request address (word aligned)
//  dmem_wdata      out  32  store data shifted into byte lanes
//  dmem_mbe        out  4   store byte enable
//  dmem_rdata      in   32  read data, valid with dmem_resp
//  dmem_resp       in   1   access complete, one-cycle pulse
//  mem_stall       out  1   hold all upstream pipeline registers
//  load_data       out  32  formatted load result, valid in DONE
//  misalign        out  1   one-cycle pulse: access suppressed (misaligned)
//  timeout         out  1   one-cycle pulse: access abandoned
//  stall_cycles    out  32  saturating count of cycles with mem_stall=1
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; all outputs 0; captured addr/data/mbe/rdata/timer 0.
//  - req = mem_read|mem_write. If both are set, treat as a load.
//  - FSM IDLE/BUSY/DONE:
//    IDLE: req & aligned -> BUSY, capturing addr_aligned, wdata = write_data << (8*bit_shift),
//          and mbe (loads: 4'b1111). req & misaligned -> DONE with misalign=1 and no dmem request.
//          Misaligned = h-type with bit_shift==3, or w-type with bit_shift!=0.
//    BUSY: dmem_read/dmem_write = captured op, driven from registers (stable until resp).
//          dmem_resp -> DONE, capturing dmem_rdata. timer==TIMEOUT_CYCLES-1 -> DONE, timeout=1,
//          load_data=0.
//    DONE: exactly one cycle, then -> IDLE unconditionally. Input req is ignored in DONE (it is
//          the same instruction).
//  - mem_stall = (IDLE & req) | BUSY (combinational). It is 0 in DONE, so EX/MEM advances.
//  - Request latency: first dmem request is 1 cycle after req is seen. Minimum stall = 2 cycles.
//  - Load format from captured rdata >> (8*offset): lb/lh sign-extend, lbu/lhu zero-extend,
//    lw passthrough. load_data is registered and holds its value until the next DONE.
//  - dmem_resp outside BUSY is ignored.
//  - Timer clears on entry to BUSY.
//  - stall_cycles saturates at 32'hFFFF_FFFF.
//  - Reset asserted mid-BUSY: request drops immediately; no partial write is retried.
// STRUCTURE
//  - rv32i_types: add mem_state_t enum {IDLE,BUSY,DONE}; reuse the load_funct3_t/store_funct3_t
//    enums.
//  - Sub-module load_formatter (combinational: rdata, offset, funct3 -> load_data), for separate
//    unit testing.
// TESTING
//  1 lw, addr 0x100, resp after 3 cycles, rdata 0xDEADBEEF -> stall 4 cycles, load_data 0xDEADBEEF.
//  2 lb off=3 / lbu off=3, rdata 0x80112233 -> load_data 0xFFFFFF80 / 0x00000080.
//  3 sh off=2, write_data 0x0000ABCD, mbe 4'b1100 -> dmem_wdata 0xABCD0000, dmem_write 1.
//  4 lh off=3 -> no dmem_read, misalign pulse, mem_stall 0 at the misalign cycle.
//  5 no resp for TIMEOUT_CYCLES -> timeout pulse, DONE, load_data 0; then IDLE.
//  6 rst low mid-BUSY -> dmem_read=0 and outputs 0 same cycle; stray resp after reset is ignored.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MEM-stage data-memory controller: FSM states,
// RV32I load/store funct3 encodings and the alignment rule.
package mem_access_unit_pkg;

  localparam int DEFAULT_TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  // Halfwords may not straddle the word (offset 3); words must start at offset 0.
  // Byte accesses are always aligned.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    logic result;
    case (funct3[1:0])
      2'b01:   result = (offset == 2'b11);
      2'b10:   result = (offset != 2'b00);
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus. master = controller side, slave = memory side.
interface mem_access_unit_if;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/mem_access_unit_load_formatter.sv
// Combinational load formatter: shifts the addressed byte/halfword of a
// memory word down to lane 0 and sign- or zero-extends it by funct3.
module mem_access_unit_load_formatter
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // Align to lane 0, then extend according to the load type.
  always_comb begin
    shifted   = rdata >> {offset, 3'b000};
    load_data = shifted;
    case (load_funct3_t'(funct3))
      LB:      load_data = {{24{shifted[7]}}, shifted[7:0]};
      LH:      load_data = {{16{shifted[15]}}, shifted[15:0]};
      LBU:     load_data = {24'b0, shifted[7:0]};
      LHU:     load_data = {16'b0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller. Runs one dmem handshake per load/store,
// stalls the pipeline until the response, formats load data for MEM/WB and
// flags misaligned or timed-out accesses.
//
//  state | meaning
//  IDLE  | waiting for a load/store from EX/MEM
//  BUSY  | request on dmem, waiting for dmem_resp or timeout
//  DONE  | one-cycle result slot; pipeline released
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [2:0]         funct3,
  input  logic [31:0]        addr_aligned,
  input  logic [1:0]         bit_shift,
  input  logic [3:0]         mem_byte_enable,
  input  logic [31:0]        write_data,
  mem_access_unit_if.master  dmem,
  output logic               mem_stall,
  output logic [31:0]        load_data,
  output logic               misalign,
  output logic               timeout,
  output logic [31:0]        stall_cycles
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  mem_state_t         state_q, state_d;
  logic               op_read_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         mbe_q;
  logic [2:0]         funct3_q;
  logic [1:0]         offset_q;
  logic [TIMER_W-1:0] timer_q;
  logic [31:0]        load_data_q;
  logic               misalign_q;
  logic               timeout_q;
  logic [31:0]        stall_cnt_q;

  logic               req;
  logic               misaligned_in;
  logic               timer_done;
  logic [31:0]        fmt_data;

  assign req           = mem_read | mem_write;
  assign misaligned_in = is_misaligned(funct3, bit_shift);
  assign timer_done    = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

  mem_access_unit_load_formatter u_load_formatter (
    .rdata     (dmem.dmem_rdata),
    .offset    (offset_q),
    .funct3    (funct3_q),
    .load_data (fmt_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and bus/stall outputs; dmem request comes only from registers.
  always_comb begin
    state_d           = state_q;
    dmem.dmem_read    = 1'b0;
    dmem.dmem_write   = 1'b0;
    dmem.dmem_address = addr_q;
    dmem.dmem_wdata   = wdata_q;
    dmem.dmem_mbe     = mbe_q;
    mem_stall         = 1'b0;
    case (state_q)
      IDLE: begin
        mem_stall = rst & req;
        if (req) state_d = misaligned_in ? DONE : BUSY;
      end
      BUSY: begin
        mem_stall       = rst;
        dmem.dmem_read  = op_read_q;
        dmem.dmem_write = ~op_read_q;
        if (dmem.dmem_resp || timer_done) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the access on entry to BUSY, run the timer and latch the result on exit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_read_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mbe_q       <= '0;
      funct3_q    <= '0;
      offset_q    <= '0;
      timer_q     <= '0;
      load_data_q <= '0;
      misalign_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req && misaligned_in) begin
            misalign_q  <= 1'b1;
            load_data_q <= '0;
          end else if (req) begin
            op_read_q <= mem_read;
            addr_q    <= addr_aligned;
            wdata_q   <= write_data << {bit_shift, 3'b000};
            mbe_q     <= mem_read ? 4'b1111 : mem_byte_enable;
            funct3_q  <= funct3;
            offset_q  <= bit_shift;
            timer_q   <= '0;
          end
        end
        BUSY: begin
          if (dmem.dmem_resp) begin
            if (op_read_q) load_data_q <= fmt_data;
          end else if (timer_done) begin
            timeout_q   <= 1'b1;
            load_data_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  stall_cnt_q <= '0;
    else if (mem_stall && stall_cnt_q != '1)   stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign load_data    = load_data_q;
  assign misalign     = misalign_q;
  assign timeout      = timeout_q;
  assign stall_cycles = stall_cnt_q;

endmodule
